// File: rtl/reset_sequencer_pkg.sv
// Shared encodings for the reset sequencer: channel trigger modes, FSM states,
// cause-register bit offsets and a counter-width helper.
package reset_sequencer_pkg;

   localparam logic [1:0] MODE_LEVEL = 2'b00;
   localparam logic [1:0] MODE_RISE  = 2'b01;
   localparam logic [1:0] MODE_FALL  = 2'b10;
   localparam logic [1:0] MODE_OFF   = 2'b11;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STRETCH   = 2'd1,
      RUN       = 2'd2
   } state_t;

   // Cause bits above the channel flags sit at CHANNELS + offset.
   localparam int CAUSE_PLL_OFS = 0;
   localparam int CAUSE_WDT_OFS = 1;

   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its surroundings.
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
#(
   parameter int CHANNELS = 2
);
   logic                    io_pllLocked;
   logic [CHANNELS-1:0]     io_resetReq;
   logic [2*CHANNELS-1:0]   io_edgeMode;
   logic                    io_causeClear;
   logic                    io_wdtEnable;
   logic                    io_wdtKick;
   logic                    io_coreReset;
   logic [CHANNELS+1:0]     io_resetCause;

   modport master (
      output io_pllLocked, io_resetReq, io_edgeMode, io_causeClear, io_wdtEnable, io_wdtKick,
      input  io_coreReset, io_resetCause
   );

   modport slave (
      input  io_pllLocked, io_resetReq, io_edgeMode, io_causeClear, io_wdtEnable, io_wdtKick,
      output io_coreReset, io_resetCause
   );
endinterface

// File: rtl/reset_sequencer_channel.sv
// One reset-request channel: synchroniser, debouncer, priming and trigger decode.
module reset_channel
   import reset_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pin_i,
   input  logic [1:0] mode_i,
   output logic       trig_o
);
   localparam int DCW = cnt_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DCW-1:0]         cnt_q, cnt_d;
   logic                   deb_q, deb_d;
   logic                   primed_q, primed_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // The first accepted level after reset only primes the channel, so an idle
   // pin that powers up in its inactive state never fakes an edge.
   always_comb begin
      cnt_d    = '0;
      deb_d    = deb_q;
      primed_d = primed_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (synced != deb_q) begin
         if (cnt_q == DCW'(DEBOUNCE_CYCLES)) begin
            deb_d    = synced;
            primed_d = 1'b1;
            rise_d   = primed_q & synced;
            fall_d   = primed_q & ~synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         deb_q    <= 1'b0;
         primed_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
         cnt_q    <= cnt_d;
         deb_q    <= deb_d;
         primed_q <= primed_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   always_comb begin
      trig_o = 1'b0;
      case (mode_i)
         MODE_LEVEL: trig_o = primed_q & deb_q;
         MODE_RISE:  trig_o = rise_q;
         MODE_FALL:  trig_o = fall_q;
         MODE_OFF:   trig_o = 1'b0;
         default:    trig_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/reset_sequencer.sv
// Core reset generator: merges PLL lock, request channels and an optional
// watchdog (enabled by RESET_SEQUENCER_WATCHDOG_EN) into a stretched reset.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int STRETCH_CYCLES  = 255,
   parameter int WDT_TIMEOUT     = 2**20
) (
   input  logic               io_mainClk,
   input  logic               io_asyncReset_n,
   reset_sequencer_if.slave   bus
);
   localparam int                  CAUSE_W   = CHANNELS + 2;
   localparam int                  SCW       = cnt_width(STRETCH_CYCLES - 1);
   localparam int                  WDT_W     = cnt_width(WDT_TIMEOUT);
   localparam logic [CAUSE_W-1:0]  CAUSE_RST = CAUSE_W'(1) << CHANNELS;

   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   lock_ok;
   logic [CHANNELS-1:0]    ch_trig;
   logic                   wdt_expire;
   logic                   trig;
   logic                   lock_loss;
   state_t                 state_q, state_d;
   logic [SCW-1:0]         scnt_q, scnt_d;
   logic                   core_reset_q, core_reset_d;
   logic [CAUSE_W-1:0]     cause_q, cause_d;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      reset_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk_i  (io_mainClk),
         .rst_ni (io_asyncReset_n),
         .pin_i  (bus.io_resetReq[c]),
         .mode_i (bus.io_edgeMode[2*c +: 2]),
         .trig_o (ch_trig[c])
      );
   end

   assign lock_ok = lock_sync_q[SYNC_STAGES-1];
   assign trig    = (|ch_trig) | wdt_expire;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
   logic [WDT_W-1:0] wdt_q, wdt_d;

   // A kick in the expiry cycle wins, so firmware kicking exactly on time is safe.
   always_comb begin
      wdt_d      = '0;
      wdt_expire = 1'b0;
      if (state_q == RUN && bus.io_wdtEnable && !bus.io_wdtKick) begin
         if (wdt_q == WDT_W'(WDT_TIMEOUT)) begin
            wdt_expire = 1'b1;
         end else begin
            wdt_d = wdt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   logic [WDT_W-1:0] unused_wdt;
   assign unused_wdt = {WDT_W{bus.io_wdtEnable ^ bus.io_wdtKick}};
   assign wdt_expire = 1'b0;
`endif

   // Lock loss is checked first in every state so it always overrides a trigger.
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      lock_loss = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_ok) begin
               state_d = STRETCH;
               scnt_d  = '0;
            end
         end
         STRETCH: begin
            if (!lock_ok) begin
               state_d   = WAIT_LOCK;
               lock_loss = 1'b1;
            end else if (trig) begin
               scnt_d = '0;
            end else if (scnt_q == SCW'(STRETCH_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_ok) begin
               state_d   = WAIT_LOCK;
               lock_loss = 1'b1;
            end else if (trig) begin
               state_d = STRETCH;
               scnt_d  = '0;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      core_reset_d = (state_d != RUN);
   end

   always_comb begin
      cause_d = bus.io_causeClear ? '0 : cause_q;
      cause_d[CHANNELS-1:0]              = cause_d[CHANNELS-1:0] | ch_trig;
      cause_d[CHANNELS + CAUSE_PLL_OFS] = cause_d[CHANNELS + CAUSE_PLL_OFS] | lock_loss;
      cause_d[CHANNELS + CAUSE_WDT_OFS] = cause_d[CHANNELS + CAUSE_WDT_OFS] | wdt_expire;
   end

   always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
      if (!io_asyncReset_n) begin
         lock_sync_q  <= '0;
         state_q      <= WAIT_LOCK;
         scnt_q       <= '0;
         core_reset_q <= 1'b1;
         cause_q      <= CAUSE_RST;
      end else begin
         lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], bus.io_pllLocked};
         state_q      <= state_d;
         scnt_q       <= scnt_d;
         core_reset_q <= core_reset_d;
         cause_q      <= cause_d;
      end
   end

   assign bus.io_coreReset  = core_reset_q;
   assign bus.io_resetCause = cause_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the board-level reset generator and single-pin falling-edge `sync_reset`.
- Merges PLL lock, CHANNELS asynchronous reset-request pins (buttons, GRESET, co-processor) and an optional watchdog into one stretched, glitch-free core reset for the Murax SoC.
- Per-channel synchroniser, debouncer and selectable trigger mode.
- Sticky reset-cause register readable by firmware through GPIO or APB.

Parameters:
- CHANNELS, 2, number of external reset-request inputs.
- SYNC_STAGES, 2, synchroniser flops per asynchronous input (≥2).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a new pin level; 0 = bypass.
- STRETCH_CYCLES, 255, io_coreReset high-time after the last trigger (≥1).
- WDT_TIMEOUT, 2**20, watchdog expiry count (used only with the watchdog feature).

Ports:
- io_mainClk  in  1  system clock.
- io_asyncReset_n  in  1  asynchronous active-low reset.
- io_pllLocked  in  1  PLL lock, asynchronous.
- io_resetReq  in  CHANNELS  asynchronous request pins.
- io_edgeMode  in  2*CHANNELS  static per-channel mode: 00 level-high, 01 rising, 10 falling, 11 disabled.
- io_causeClear  in  1  single-cycle clear of io_resetCause.
- io_wdtEnable  in  1  watchdog enable.
- io_wdtKick  in  1  watchdog restart pulse.
- io_coreReset  out  1  active-high core reset, registered.
- io_resetCause  out  CHANNELS+2  sticky flags: [CHANNELS-1:0] channels, [CHANNELS] PLL/power-on, [CHANNELS+1] watchdog.

Behaviour:
- Reset values while io_asyncReset_n=0:
  - io_coreReset=1.
  - io_resetCause = only bit CHANNELS set.
  - Synchroniser flops, debounce counters, primed bits, stretch counter and watchdog all 0.
  - FSM in WAIT_LOCK.
- Synchronisers: SYNC_STAGES flops on io_pllLocked and on each io_resetReq bit.
- Debounce, per channel:
  - Counter increments while the synchronised value ≠ the debounced value; it clears on any agreeing cycle.
  - Debounced value takes the synchronised value when the count reaches DEBOUNCE_CYCLES.
  - Priming: the first acceptance after reset sets the channel's primed bit and produces no edge.
- Trigger per channel, one cycle, only when primed:
  - level-high: asserted every cycle the debounced value is 1.
  - rising: on a debounced 0→1.
  - falling: on a debounced 1→0.
  - disabled: never.
- OR of all triggers (plus watchdog expiry) = trig.
- FSM:
  - WAIT_LOCK: io_coreReset=1. Goes to STRETCH, counter cleared, when the synchronised lock=1.
  - STRETCH: io_coreReset=1. Counter increments each cycle.
    - trig clears the counter and restarts the stretch.
    - Lock=0 goes to WAIT_LOCK.
    - Count reaching STRETCH_CYCLES-1 goes to RUN.
  - RUN: io_coreReset=0.
    - trig goes to STRETCH.
    - Lock=0 goes to WAIT_LOCK.
  - Lock loss has priority over trig.
- Latency:
  - io_coreReset rises on the clock edge after trig.
  - Pin-to-reset latency = SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles.
  - Deassertion comes exactly STRETCH_CYCLES cycles after the last trig.
- Level mode held high keeps io_coreReset high indefinitely.
- Cause register:
  - Bit set on its source event: channel trigger, lock loss in STRETCH or RUN, watchdog expiry.
  - Cleared by io_causeClear.
  - Set wins over a simultaneous clear.
  - Not cleared by io_coreReset, so firmware can read it after reboot.
- Mode changes take effect next cycle; they need not be glitch-safe.

Optional Feature:
- RESET_SEQUENCER_WATCHDOG_EN defined:
  - ceil(log2(WDT_TIMEOUT+1))-bit counter increments in RUN while io_wdtEnable=1.
  - io_wdtKick, io_wdtEnable=0, or any state other than RUN clears it.
  - Reaching WDT_TIMEOUT gives a one-cycle trig and sets cause bit CHANNELS+1; the counter then clears.
  - Kick and expiry in the same cycle: kick wins.
- Undefined:
  - No counter; io_wdtEnable and io_wdtKick are ignored.
  - Cause bit CHANNELS+1 is constant 0.
  - Port list is unchanged.

Decomposition:
- Package reset_sequencer_pkg holds:
  - Mode encodings MODE_LEVEL, MODE_RISE, MODE_FALL, MODE_OFF.
  - FSM state typedef {WAIT_LOCK, STRETCH, RUN}.
  - Cause bit-index constants.
- One sub-module, reset_channel (synchroniser + debounce + priming + edge detect), instantiated CHANNELS times; the FSM, cause register and watchdog stay in the top.

Test Plan:
- Setup for the scenarios below: CHANNELS=2, DEBOUNCE_CYCLES=1000, STRETCH_CYCLES=255, unless stated.
- Power-on: lock=1 from the start, release io_asyncReset_n → io_coreReset high until cycle SYNC_STAGES+1+255, then 0; cause=4'b0100.
- Channel 0 falling mode, pin idle high:
  - Pin driven low 1005 cycles → exactly one 255-cycle reset, cause[0]=1.
  - Low glitch of 999 cycles → no reset, cause unchanged.
- Channel 1 level mode, pin held high 2000 cycles → io_coreReset high throughout and for 255 cycles after the debounced release.
- Lock dropped at STRETCH count 100 → WAIT_LOCK, io_coreReset stays 1; relock → full 255-cycle stretch; cause[2]=1.
- io_causeClear asserted in the same cycle as a channel-0 trigger → cause[0] remains 1; clear alone one cycle later → cause=0.
- WATCHDOG_EN, WDT_TIMEOUT=100:
  - Enabled with no kick → io_coreReset rises 101 cycles into RUN, cause[3]=1.
  - Kick every 50 cycles → no reset over 10000 cycles.
